// File: rtl/hazard_ctrl_if.sv
// Port bundle for hazard_ctrl: pipeline-side addresses and control in, selects/stalls/flushes out.
// The perf-counter outputs exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC*ADDR_W-1:0] i_rs_addr_e;
    logic [NUM_SRC*ADDR_W-1:0] i_rs_addr_d;
    logic [NUM_SRC-1:0]        i_rs_used_d;
    logic [ADDR_W-1:0]         i_rd_addr_d;
    logic                      i_rd_used_d;
    logic [ADDR_W-1:0]         i_rd_addr_e;
    logic                      i_mem_read_e;
    logic [ADDR_W-1:0]         i_rd_addr_m;
    logic                      i_reg_write_m;
    logic [ADDR_W-1:0]         i_rd_addr_w;
    logic                      i_reg_write_w;
    logic                      i_lu_issue;
    logic [ADDR_W-1:0]         i_lu_issue_rd;
    logic                      i_lu_done;
    logic [ADDR_W-1:0]         i_lu_done_rd;
    logic                      i_redirect_e;
    logic [2*NUM_SRC-1:0]      o_fwd_sel;
    logic                      o_stall_f;
    logic                      o_stall_d;
    logic                      o_flush_d;
    logic                      o_flush_e;
    logic                      o_sb_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]               o_stall_cnt;
    logic [31:0]               o_flush_cnt;
`endif

    modport master (
        output i_rs_addr_e, i_rs_addr_d, i_rs_used_d, i_rd_addr_d, i_rd_used_d,
        output i_rd_addr_e, i_mem_read_e, i_rd_addr_m, i_reg_write_m,
        output i_rd_addr_w, i_reg_write_w, i_lu_issue, i_lu_issue_rd,
        output i_lu_done, i_lu_done_rd, i_redirect_e,
`ifdef HAZARD_PERF_CNT_EN
        input  o_stall_cnt, o_flush_cnt,
`endif
        input  o_fwd_sel, o_stall_f, o_stall_d, o_flush_d, o_flush_e, o_sb_busy
    );

    modport slave (
        input  i_rs_addr_e, i_rs_addr_d, i_rs_used_d, i_rd_addr_d, i_rd_used_d,
        input  i_rd_addr_e, i_mem_read_e, i_rd_addr_m, i_reg_write_m,
        input  i_rd_addr_w, i_reg_write_w, i_lu_issue, i_lu_issue_rd,
        input  i_lu_done, i_lu_done_rd, i_redirect_e,
`ifdef HAZARD_PERF_CNT_EN
        output o_stall_cnt, o_flush_cnt,
`endif
        output o_fwd_sel, o_stall_f, o_stall_d, o_flush_d, o_flush_e, o_sb_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: M/W forwarding selects, load-use bubbles, long-latency scoreboard, redirect flush.
// Optional stall/flush performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_STALL = 1
) (
    input logic          i_clk,
    input logic          i_rst_n,
    hazard_ctrl_if.slave hz
);
    localparam int         NUM_REGS    = 2**ADDR_W;
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_LSTALL   = 1'b1;
    localparam logic [2:0] CNT_INIT    = 3'(LOAD_STALL - 1);
    localparam logic       MULTI_STALL = (LOAD_STALL > 1);

    logic [0:0]           state_r;
    logic [0:0]           state_nxt_s;
    logic [2:0]           cnt_r;
    logic [2:0]           cnt_nxt_s;
    logic [NUM_REGS-1:0]  busy_r;
    logic [NUM_REGS-1:0]  busy_nxt_s;
    logic [NUM_REGS-1:0]  set_mask_s;
    logic [NUM_REGS-1:0]  clr_mask_s;
    logic                 lu_hit_s;
    logic                 sb_hit_s;
    logic                 stall_req_s;
    logic [2*NUM_SRC-1:0] fwd_sel_s;
    logic                 stall_f_s;
    logic                 stall_d_s;
    logic                 flush_d_s;
    logic                 flush_e_s;
    logic                 sb_busy_s;

    // Register 0 is hardwired to zero and therefore never a forwarding or hazard source.
    function automatic logic addr_match(input logic en, input logic [ADDR_W-1:0] rd,
                                        input logic [ADDR_W-1:0] rs);
        return en && (rd != {ADDR_W{1'b0}}) && (rd == rs);
    endfunction

    // Load-use and scoreboard hazard detection against the instruction in D.
    always_comb begin
        lu_hit_s = 1'b0;
        sb_hit_s = hz.i_rd_used_d && busy_r[hz.i_rd_addr_d];
        for (int k = 0; k < NUM_SRC; k++) begin
            if (hz.i_rs_used_d[k]) begin
                lu_hit_s = lu_hit_s |
                           addr_match(hz.i_mem_read_e, hz.i_rd_addr_e,
                                      hz.i_rs_addr_d[k*ADDR_W +: ADDR_W]);
                sb_hit_s = sb_hit_s | busy_r[hz.i_rs_addr_d[k*ADDR_W +: ADDR_W]];
            end else begin
                lu_hit_s = lu_hit_s;
                sb_hit_s = sb_hit_s;
            end
        end
    end

    // Scoreboard next state: set is applied after clear so a same-register issue/done stays busy.
    always_comb begin
        clr_mask_s = hz.i_lu_done ? (NUM_REGS'(1'b1) << hz.i_lu_done_rd) : {NUM_REGS{1'b0}};
        set_mask_s = (hz.i_lu_issue && (hz.i_lu_issue_rd != {ADDR_W{1'b0}})) ?
                     (NUM_REGS'(1'b1) << hz.i_lu_issue_rd) : {NUM_REGS{1'b0}};
        busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end

    // Load-use bubble sequencer: the IDLE hit cycle is the first bubble, LSTALL supplies the rest.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (MULTI_STALL && lu_hit_s && !hz.i_redirect_e) begin
                    state_nxt_s = ST_LSTALL;
                    cnt_nxt_s   = CNT_INIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 3'd0;
                end
            end
            ST_LSTALL: begin
                if (hz.i_redirect_e || (cnt_r <= 3'd1)) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 3'd0;
                end else begin
                    state_nxt_s = ST_LSTALL;
                    cnt_nxt_s   = cnt_r - 3'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    assign stall_req_s = (state_r == ST_LSTALL) || lu_hit_s || sb_hit_s;

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        fwd_sel_s = {2*NUM_SRC{1'b0}};
        stall_f_s = 1'b0;
        stall_d_s = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        sb_busy_s = 1'b0;
        if (!i_rst_n) begin
            fwd_sel_s = {2*NUM_SRC{1'b0}};
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (addr_match(hz.i_reg_write_m, hz.i_rd_addr_m, hz.i_rs_addr_e[k*ADDR_W +: ADDR_W])) begin
                    fwd_sel_s[2*k +: 2] = 2'b10;
                end else if (addr_match(hz.i_reg_write_w, hz.i_rd_addr_w, hz.i_rs_addr_e[k*ADDR_W +: ADDR_W])) begin
                    fwd_sel_s[2*k +: 2] = 2'b01;
                end else begin
                    fwd_sel_s[2*k +: 2] = 2'b00;
                end
            end
            // A redirect kills the stalled instruction, so it overrides any hold request.
            stall_f_s = stall_req_s && !hz.i_redirect_e;
            stall_d_s = stall_req_s && !hz.i_redirect_e;
            flush_d_s = hz.i_redirect_e;
            flush_e_s = stall_req_s || hz.i_redirect_e;
            sb_busy_s = |busy_r;
        end
    end

    assign hz.o_fwd_sel = fwd_sel_s;
    assign hz.o_stall_f = stall_f_s;
    assign hz.o_stall_d = stall_d_s;
    assign hz.o_flush_d = flush_d_s;
    assign hz.o_flush_e = flush_e_s;
    assign hz.o_sb_busy = sb_busy_s;

    // Stall sequencer and scoreboard state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            busy_r  <= {NUM_REGS{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Free-running event counters, wrapping naturally at 2**32.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            stall_cnt_r <= stall_d_s       ? (stall_cnt_r + 32'd1) : stall_cnt_r;
            flush_cnt_r <= hz.i_redirect_e ? (flush_cnt_r + 32'd1) : flush_cnt_r;
        end
    end

    assign hz.o_stall_cnt = stall_cnt_r;
    assign hz.o_flush_cnt = flush_cnt_r;
`endif
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage core and successor to the EX-stage forwarding unit. It generates per-operand forwarding selects for N source operands from the MEM and WB stages. It also detects load-use hazards and inserts a parametrised number of stall cycles. A register scoreboard stalls decode on RAW and WAW hazards against a long-latency unit (mul/div), and redirect-driven flushes take priority over stalls.

Parameters:
ADDR_W, 5, register address width; register file has 2**ADDR_W entries
NUM_SRC, 2, number of source operands per instruction in D and E
LOAD_STALL, 1, bubbles inserted per load-use hazard (1..7)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_rs_addr_e  in  NUM_SRC*ADDR_W  packed source addresses of instruction in E (src k at [k*ADDR_W +: ADDR_W])
i_rs_addr_d  in  NUM_SRC*ADDR_W  packed source addresses of instruction in D
i_rs_used_d  in  NUM_SRC  source k actually read by D instruction
i_rd_addr_d  in  ADDR_W  destination of D instruction
i_rd_used_d  in  1  D instruction writes a register
i_rd_addr_e  in  ADDR_W  destination of E instruction
i_mem_read_e  in  1  E instruction is a load
i_rd_addr_m  in  ADDR_W  destination in M
i_reg_write_m  in  1  M writes register
i_rd_addr_w  in  ADDR_W  destination in W
i_reg_write_w  in  1  W writes register
i_lu_issue  in  1  long-latency op issued from E this cycle
i_lu_issue_rd  in  ADDR_W  its destination
i_lu_done  in  1  long-latency result written back this cycle
i_lu_done_rd  in  ADDR_W  its destination
i_redirect_e  in  1  branch/jump taken in E
o_fwd_sel  out  2*NUM_SRC  per-source select at [2k +: 2]: 00 regfile, 10 from M, 01 from W
o_stall_f  out  1  hold PC
o_stall_d  out  1  hold IF/ID register
o_flush_d  out  1  bubble IF/ID register
o_flush_e  out  1  bubble ID/EX register
o_sb_busy  out  1  at least one scoreboard bit set

Behaviour:
- Reset (i_rst_n low, async): all outputs 0, scoreboard cleared, stall FSM to IDLE, counter 0. Outputs forced 0 for as long as reset is asserted.
- Forwarding (combinational, per source k): M match (i_reg_write_m, rd_m != 0, rd_m == rs_e[k]) -> 10. Otherwise W match under the same rules -> 01. Otherwise 00. M wins over W. Address 0 never forwarded.
- Load-use: hit when i_mem_read_e, rd_e != 0, and rd_e == rs_d[k] for any k with i_rs_used_d[k]=1.
- Stall FSM states:
  - IDLE: a hit asserts o_stall_f, o_stall_d and o_flush_e in the same cycle. If LOAD_STALL>1, go to LSTALL with cnt = LOAD_STALL-1.
  - LSTALL: same three outputs asserted; cnt decrements each cycle; return to IDLE after the cycle in which cnt reaches 1.
  - Total bubbles per hazard = LOAD_STALL exactly.
- Scoreboard: 2**ADDR_W busy bits.
  - i_lu_issue sets bit[issue_rd]; i_lu_done clears bit[done_rd].
  - Issue and done to the same register in the same cycle: set wins.
  - Bit 0 is never set.
  - Register updates on i_clk; o_sb_busy = OR of all bits (registered state).
- Scoreboard stall: D reads a busy source (used), or D writes a busy rd (i_rd_used_d, WAW). Either asserts o_stall_f, o_stall_d and o_flush_e. A done in the same cycle does not release the stall; the stall releases the following cycle.
- Redirect: i_redirect_e asserts o_flush_d and o_flush_e. It forces o_stall_f and o_stall_d to 0 and aborts LSTALL to IDLE at the next edge. The scoreboard is unaffected.
- Load-use and scoreboard stalls may overlap; the outputs are the OR of both.

Optional Feature:
HAZARD_PERF_CNT_EN: adds o_stall_cnt[31:0] and o_flush_cnt[31:0].
- o_stall_cnt increments each cycle o_stall_d=1.
- o_flush_cnt increments each cycle i_redirect_e=1.
- Both counters wrap at 2**32 and reset to 0.
- Without the macro, the ports and logic are absent.

Test Plan:
- Forwarding: rd_m=5, rd_w=5, both writing, rs_e[0]=5 -> sel[1:0]=10. Clear reg_write_m -> sel[1:0]=01. Set rd_m=rd_w=0 -> 00.
- Load-use: LOAD_STALL=1, load rd_e=7, rs_d[1]=7 used -> stall_f, stall_d, flush_e high exactly 1 cycle. Rerun with LOAD_STALL=3 -> high exactly 3 cycles.
- Scoreboard RAW: issue rd=9, then D rs_d[0]=9 -> stall held. Assert done rd=9 in cycle N -> stall low in cycle N+1; o_sb_busy drops in cycle N+1.
- WAW with simultaneous issue/done: issue and done both rd=4 in the same cycle -> bit 4 stays set. D with rd=4 used -> stall.
- Redirect during LSTALL (LOAD_STALL=3, redirect in the 2nd stall cycle) -> flush_d=flush_e=1, stall_f=stall_d=0 that cycle; no stall the next cycle.
- Async reset mid-stall with busy bits set -> all outputs 0 immediately; o_sb_busy=0 after release.
